mux16_rr_scheduler: RTL and testbench

// Round-robin scheduler that shares one mux16to1 among 16 requesters by driving its
// sel/en. Requester i owns mux input data_in[i]; while granted, the mux output y

---
 rtl/mux16_rr_scheduler.sv | 156 +++++++++++++++
 tb/tb_mux16_rr_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux16_rr_scheduler.sv
// Round-robin scheduler driving the sel/en pair of a 16:1 mux.
// Each grant is a burst of at most MAX_HOLD cycles. The search for the next
// winner starts just after the last owner, so no requester starves. Every
// output comes from a register; req never reaches an output combinationally.
module mux16_rr_scheduler #(
  parameter int NUM_REQ  = 16,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sched_en,
  input  logic [NUM_REQ-1:0] req,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_done
);

  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic               r_en;
  logic               w_en_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_ptr_nxt;

  logic               w_req_any;
  logic [SEL_W-1:0]   w_start;
  logic [SEL_W-1:0]   w_winner;
  logic               w_end;

  // Return the first set bit of rq, scanning upward from start and wrapping at NUM_REQ.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] rq,
                                               input logic [SEL_W-1:0]   start);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = start + SEL_W'(k);
      if (!found && rq[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Build the one-hot grant vector for a given select value.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
    onehot = NUM_REQ'(1) << s;
  endfunction

  assign w_req_any = |req;

  // While a grant is active, the search starts just after the owner. The
  // owner is therefore the last candidate and wins again only when it is
  // the sole requester.
  assign w_start  = (r_state == GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;
  assign w_winner = rr_pick(req, w_start);

  // End the grant on any of: scheduling off, the owner releasing its
  // request, or the burst reaching its hold limit.
  assign w_end = !sched_en || !req[r_sel] || (r_cnt == CNT_W'(MAX_HOLD));

  // Next-state and next-output decode for the IDLE/GRANT controller.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_en_nxt    = r_en;
    w_grant_nxt = r_grant;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (sched_en && w_req_any) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_winner;
          w_en_nxt    = 1'b1;
          w_grant_nxt = onehot(w_winner);
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_en_nxt    = 1'b0;
          w_grant_nxt = '0;
        end
      end
      GRANT: begin
        if (!w_end) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end else begin
          w_done_nxt = 1'b1;
          w_ptr_nxt  = w_start;
          if (sched_en && w_req_any) begin
            // Hand off on the same edge, so en has no idle bubble.
            w_sel_nxt   = w_winner;
            w_en_nxt    = 1'b1;
            w_grant_nxt = onehot(w_winner);
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_state_nxt = IDLE;
            w_en_nxt    = 1'b0;
            w_grant_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_en_nxt    = 1'b0;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous, so asserting it
  // mid-grant clears the outputs without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_en    <= 1'b0;
      r_grant <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_en    <= w_en_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign sel        = r_sel;
  assign en         = r_en;
  assign grant      = r_grant;
  assign grant_done = r_done;

endmodule

// File: tb/tb_mux16_rr_scheduler.sv
// Bench for mux16_rr_scheduler. It runs two instances side by side, one with
// MAX_HOLD=8 and one with MAX_HOLD=2, and drives both with the same inputs.
// A behavioural model of the round-robin rules predicts every output, and a
// behavioural 16:1 mux is placed on each scheduler's sel/en.
module tb_mux16_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sched_en;
  logic [15:0] req;
  logic [15:0] data_in;

  logic [3:0]  sel_a, sel_b;
  logic        en_a, en_b;
  logic [15:0] grant_a, grant_b;
  logic        done_a, done_b;
  logic        y_a, y_b;

  always #5 clk = ~clk;

  mux16_rr_scheduler #(.NUM_REQ(16), .SEL_W(4), .MAX_HOLD(8)) u_a (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .req(req),
    .sel(sel_a), .en(en_a), .grant(grant_a), .grant_done(done_a));

  mux16_rr_scheduler #(.NUM_REQ(16), .SEL_W(4), .MAX_HOLD(2)) u_b (
    .clk(clk), .rst_n(rst_n), .sched_en(sched_en), .req(req),
    .sel(sel_b), .en(en_b), .grant(grant_b), .grant_done(done_b));

  // Behavioural mux16to1 placed on each scheduler.
  assign y_a = en_a ? data_in[sel_a] : 1'b0;
  assign y_b = en_b ? data_in[sel_b] : 1'b0;

  int hold [2] = '{8, 2};
  int m_busy [2];
  int m_own  [2];
  int m_cnt  [2];
  int m_ptr  [2];
  int m_done [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int scan(input logic [15:0] r, input int start);
    for (int k = 0; k < 16; k++)
      if (r[(start + k) % 16]) return (start + k) % 16;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_own[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0; m_done[d] = 0;
    end
  endtask

  // Advance both models by one clock edge, using the inputs seen at that edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      m_done[d] = 0;
      if (m_busy[d] == 0) begin
        if (sched_en && req != 16'h0) begin
          m_own[d] = scan(req, m_ptr[d]); m_cnt[d] = 1; m_busy[d] = 1;
        end
      end else if (sched_en && req[m_own[d]] && m_cnt[d] < hold[d]) begin
        m_cnt[d]++;
      end else begin
        m_done[d] = 1;
        m_ptr[d]  = (m_own[d] + 1) % 16;
        if (sched_en && req != 16'h0) begin
          m_own[d] = scan(req, m_ptr[d]); m_cnt[d] = 1;
        end else begin
          m_busy[d] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [3:0]  s;
    logic        e, dn, y;
    logic [15:0] g;
    for (int d = 0; d < 2; d++) begin
      s  = d ? sel_b   : sel_a;
      e  = d ? en_b    : en_a;
      g  = d ? grant_b : grant_a;
      dn = d ? done_b  : done_a;
      y  = d ? y_b     : y_a;
      check($sformatf("sel%0d", d), 32'(s), 32'(m_own[d]));
      check($sformatf("en%0d", d), 32'(e), 32'(m_busy[d]));
      check($sformatf("grant%0d", d), 32'(g), m_busy[d] ? (32'h1 << m_own[d]) : 32'h0);
      check($sformatf("done%0d", d), 32'(dn), 32'(m_done[d]));
      check($sformatf("y%0d", d), 32'(y), m_busy[d] ? 32'(data_in[m_own[d]]) : 32'h0);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();
      data_in = 16'($urandom);
    end
  endtask

  // Assert reset between edges and confirm the outputs clear before any clock.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_sel", 32'(sel_a), 32'h0);
    check("rst_en", 32'(en_a), 32'h0);
    check("rst_grant", 32'(grant_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int rot_exp [10] = '{0, 0, 1, 1, 15, 15, 0, 0, 1, 1};

  initial begin
    rst_n    = 1'b0;
    sched_en = 1'b1;
    req      = 16'h0;
    data_in  = 16'($urandom);
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-grant, then one-edge latency after release.
    req = 16'h0020;
    cyc(1);
    check("lat_sel5", 32'(sel_a), 32'd5);
    check("lat_en", 32'(en_a), 32'd1);
    cyc(3);
    async_reset();
    req = 16'h0001;
    cyc(1);
    check("post_rst_sel", 32'(sel_a), 32'd0);
    check("post_rst_en", 32'(en_a), 32'd1);

    // A sole requester gets a MAX_HOLD burst, then wins again.
    async_reset();
    req = 16'h0020;
    cyc(8);
    check("burst_en", 32'(en_a), 32'd1);
    check("burst_nodone", 32'(done_a), 32'd0);
    cyc(1);
    check("burst_done", 32'(done_a), 32'd1);
    check("burst_regrant", 32'(sel_a), 32'd5);
    check("burst_en_kept", 32'(en_a), 32'd1);
    cyc(7);
    check("burst2_nodone", 32'(done_a), 32'd0);
    cyc(1);
    check("burst2_done", 32'(done_a), 32'd1);

    // Rotation with MAX_HOLD=2.
    async_reset();
    req = 16'h8003;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("rot_sel", 32'(sel_b), 32'(rot_exp[i]));
      check("rot_en", 32'(en_b), 32'd1);
    end

    // The owner drops its request; the next winner is found by wrapping.
    async_reset();
    req = 16'h0008;
    cyc(1);
    check("early_sel3", 32'(sel_a), 32'd3);
    cyc(1);
    req = 16'h0004;
    cyc(1);
    check("early_done", 32'(done_a), 32'd1);
    check("early_sel2", 32'(sel_a), 32'd2);
    check("early_en", 32'(en_a), 32'd1);

    // sched_en low ends the grant; the pointer is kept for later.
    sched_en = 1'b0;
    cyc(1);
    check("sen_en0", 32'(en_a), 32'd0);
    check("sen_done", 32'(done_a), 32'd1);
    cyc(3);
    check("sen_idle", 32'(en_a), 32'd0);
    req      = 16'h0011;
    sched_en = 1'b1;
    cyc(1);
    check("sen_resume", 32'(sel_a), 32'd4);

    // Randomized traffic, including occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       req = 16'($urandom);
        1:       req = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2:       req = req;
        default: req = 16'h1 << $urandom_range(0, 15);
      endcase
      sched_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 299) == 0) async_reset();
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
